// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: initialises all 16 registers after reset, then
// round-robin arbitrates between the ALU (A) and memory-load (B) writeback paths.
module regfile_wb_arbiter #(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                ZERO_R0    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [3:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [3:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_WriteReg,
  output logic [3:0]        rf_DstReg,
  output logic [DATA_W-1:0] rf_DstData,
  output logic              init_busy,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic              we_q, we_d;
  logic [3:0]        dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        conf_q, conf_d;
  logic              grant_a, grant_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    we_d     = 1'b0;
    dst_d    = dst_q;
    data_d   = data_q;
    conf_d   = conf_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;

    case (state_q)
      S_INIT: begin
        we_d   = 1'b1;
        dst_d  = cnt_q;
        data_d = INIT_VALUE;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Ready is gated by rst so a request is never acknowledged on a reset edge.
        grant_a = rst && a_valid && (!b_valid || last_b_q);
        grant_b = rst && b_valid && !grant_a;
        if (a_valid && b_valid && conf_q != 8'hFF) begin
          conf_d = conf_q + 8'd1;
        end
        if (grant_a) begin
          dst_d    = a_reg;
          data_d   = a_data;
          we_d     = !(ZERO_R0 && a_reg == 4'd0);
          last_b_d = 1'b0;
        end else if (grant_b) begin
          dst_d    = b_reg;
          data_d   = b_data;
          we_d     = !(ZERO_R0 && b_reg == 4'd0);
          last_b_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_INIT;
      cnt_q    <= 4'd0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      dst_q    <= 4'd0;
      data_q   <= '0;
      conf_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      conf_q   <= conf_d;
    end
  end

  assign a_ready      = grant_a;
  assign b_ready      = grant_b;
  assign rf_WriteReg  = we_q;
  assign rf_DstReg    = dst_q;
  assign rf_DstData   = data_q;
  assign init_busy    = (state_q == S_INIT);
  assign conflict_cnt = conf_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against a cycle-level behavioural model
// with an array model of the register file.
module tb_regfile_wb_arbiter;

  localparam logic [15:0] INIT_V = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_reg = '0, b_reg = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        rf_WriteReg;
  logic [3:0]  rf_DstReg;
  logic [15:0] rf_DstData;
  logic        init_busy;
  logic [7:0]  conflict_cnt;

  regfile_wb_arbiter #(.DATA_W(16), .INIT_VALUE(INIT_V), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rf_WriteReg(rf_WriteReg), .rf_DstReg(rf_DstReg), .rf_DstData(rf_DstData),
    .init_busy(init_busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit          m_init   = 1'b1;
  int          m_cnt    = 0;
  bit          m_last_b = 1'b1;
  int          m_conf   = 0;
  bit          e_we     = 1'b0;
  int          e_reg    = 0;
  int          e_data   = 0;
  logic [15:0] model_rf  [16];
  logic [15:0] shadow_rf [16];
  logic        last_a_rdy, last_b_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    bit ga, gb;
    #3;
    ga = 1'b0;
    gb = 1'b0;
    if (rst && !m_init) begin
      if (a_valid && b_valid) begin
        if (m_last_b) ga = 1'b1; else gb = 1'b1;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    last_a_rdy = a_ready;
    last_b_rdy = b_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_init = 1'b1; m_cnt = 0; m_last_b = 1'b1; m_conf = 0;
      e_we = 1'b0; e_reg = 0; e_data = 0;
    end else if (m_init) begin
      e_we = 1'b1; e_reg = m_cnt; e_data = INIT_V;
      model_rf[m_cnt] = INIT_V;
      if (m_cnt == 15) m_init = 1'b0;
      m_cnt++;
    end else begin
      if (a_valid && b_valid && m_conf < 255) m_conf++;
      e_we = 1'b0;
      if (ga || gb) begin
        e_reg  = ga ? a_reg : b_reg;
        e_data = ga ? a_data : b_data;
        e_we   = (e_reg != 0);
        if (e_we) model_rf[e_reg] = e_data[15:0];
        m_last_b = gb;
        $display("grant %s r%0d <= %04h%s", ga ? "A" : "B", e_reg, e_data[15:0],
                 e_we ? "" : " (suppressed)");
      end
    end
    check("rf_WriteReg", rf_WriteReg, e_we);
    check("rf_DstReg", rf_DstReg, e_reg);
    check("rf_DstData", rf_DstData, e_data);
    check("init_busy", init_busy, m_init);
    check("conflict_cnt", conflict_cnt, m_conf);
    if (rf_WriteReg === 1'b1) shadow_rf[rf_DstReg] = rf_DstData;
    if (ga) a_valid = 1'b0;
    if (gb) b_valid = 1'b0;
  endtask

  task automatic raise_a(input logic [3:0] r, input logic [15:0] d);
    a_valid = 1'b1; a_reg = r; a_data = d;
  endtask

  task automatic raise_b(input logic [3:0] r, input logic [15:0] d);
    b_valid = 1'b1; b_reg = r; b_data = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (a_valid || b_valid); k++) step();
    check("drain_done", {a_valid, b_valid}, 2'b00);
  endtask

  task automatic rand_fill(input int pct);
    if (!a_valid && $urandom_range(0, 99) < pct) raise_a(4'($urandom), 16'($urandom));
    if (!b_valid && $urandom_range(0, 99) < pct) raise_b(4'($urandom), 16'($urandom));
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) begin
      model_rf[i]  = 16'hDEAD;
      shadow_rf[i] = 16'hDEAD;
    end

    // Reset, then init with both requesters already waiting
    rst = 1'b0;
    step(); step();
    check("rst_busy", init_busy, 1'b1);
    rst = 1'b1;
    raise_a(4'd5, 16'h5555);
    raise_b(4'd6, 16'h6666);
    for (int i = 0; i < 16; i++) begin
      step();
      check("init_seq_reg", rf_DstReg, i);
      check("init_seq_we", rf_WriteReg, 1'b1);
    end
    check("init_done", init_busy, 1'b0);
    drain();

    // A alone
    raise_a(4'd7, 16'h3099);
    step();
    check("a7_ready", last_a_rdy, 1'b1);
    check("a7_reg", rf_DstReg, 4'd7);
    check("a7_data", rf_DstData, 16'h3099);
    step();
    check("a7_rf", shadow_rf[7], 16'h3099);

    // B writes R0: accepted but suppressed
    raise_b(4'd0, 16'h808A);
    step();
    check("r0_ready", last_b_rdy, 1'b1);
    check("r0_we", rf_WriteReg, 1'b0);
    step();
    check("r0_rf", shadow_rf[0], INIT_V);

    // Four cycles of contention: A,B,A,B
    base = m_conf;
    for (int i = 0; i < 4; i++) begin
      if (!a_valid) raise_a(4'(1 + i), 16'h1111 * 16'(i + 1));
      if (!b_valid) raise_b(4'(3 + i), 16'hBBBB - 16'(i));
      step();
      check("tie_order_a", last_a_rdy, (i % 2 == 0));
    end
    check("conf_delta", int'(conflict_cnt) - base, 4);
    drain();

    // Reset mid-run with both valid
    raise_a(4'd9, 16'h9999);
    raise_b(4'd10, 16'hAAAA);
    rst = 1'b0;
    step();
    check("mr_we", rf_WriteReg, 1'b0);
    check("mr_conf", conflict_cnt, 8'd0);
    check("mr_busy", init_busy, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("reinit_reg", rf_DstReg, i);
    end
    check("reinit_r7", shadow_rf[7], INIT_V);
    drain();

    // Reset at init cnt=9
    rst = 1'b0; step();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b0; step();
    rst = 1'b1; step();
    check("restart_r0", rf_DstReg, 4'd0);
    for (int i = 1; i < 16; i++) step();
    check("restart_done", init_busy, 1'b0);

    // Saturation under sustained contention
    for (int i = 0; i < 300; i++) begin
      rand_fill(100);
      step();
    end
    check("conf_sat", conflict_cnt, 8'hFF);
    drain();

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      rand_fill(60);
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step();
    drain();
    for (int i = 0; i < 16; i++) check("final_rf", shadow_rf[i], model_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 16x16 register file and shares it between two writeback requesters: A (ALU path) and B (memory-load path).
- After every reset, a sequencer first writes INIT_VALUE into all 16 registers. It then enters run mode and arbitrates round-robin between the requesters using valid/ready handshakes.
- Sits between the writeback stage and the register file's WriteReg/DstReg/DstData inputs.

Parameters:
- DATA_W, 16, width of writeback data and of the register-file data port.
- INIT_VALUE, 16'h0000, value written to every register during the init sequence.
- ZERO_R0, 1: when 1, run-mode writes to register 0 are accepted but suppressed (WriteReg stays 0). When 0, R0 is writable.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- a_valid  in  1  requester A has a write pending.
- a_reg  in  4  A destination register.
- a_data  in  DATA_W  A write data.
- a_ready  out  1  A's write is accepted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_reg  in  4  B destination register.
- b_data  in  DATA_W  B write data.
- b_ready  out  1  B's write is accepted this cycle.
- rf_WriteReg  out  1  register-file write enable (registered).
- rf_DstReg  out  4  register-file destination (registered).
- rf_DstData  out  DATA_W  register-file write data (registered).
- init_busy  out  1  high while the init sequence is running.
- conflict_cnt  out  8  saturating count of cycles where both requesters were valid in run mode.

Behaviour:
- Reset (rst==0 at a rising edge, any state):
  - state<=INIT, init counter<=0, last_grant<=B (so A wins the first tie).
  - rf_WriteReg<=0, rf_DstReg<=0, rf_DstData<=0, conflict_cnt<=0, init_busy<=1.
  - No pending request is written.
  - Reset asserted mid-init or mid-run aborts that activity and restarts init once rst returns high.
- INIT state, each edge with rst==1:
  - rf_WriteReg<=1, rf_DstReg<=cnt, rf_DstData<=INIT_VALUE, cnt<=cnt+1.
  - On the edge that issues cnt==15, state<=RUN and init_busy<=0.
  - Registers are written in order 0..15, exactly 16 consecutive write cycles.
  - R0 is initialised regardless of ZERO_R0.
  - a_ready=b_ready=0 throughout INIT.
- RUN state, combinational grant:
  - Only A valid -> A wins. Only B valid -> B wins.
  - Both valid -> the requester that is not last_grant wins.
  - Winner's ready=1. Loser's ready=0. Neither valid -> both ready=0.
  - ready never asserts without the matching valid.
- Acceptance: a handshake occurs when valid&&ready. At that edge:
  - rf_DstReg<=winner reg, rf_DstData<=winner data.
  - rf_WriteReg<=1, except 0 when ZERO_R0==1 and reg==0.
  - last_grant<=winner.
  - Latency is exactly 1 cycle from acceptance to the write appearing on the rf_* outputs.
- No handshake in RUN -> rf_WriteReg<=0. rf_DstReg and rf_DstData hold their last values.
- Requester rule: once valid is raised, reg and data stay stable and valid stays high until ready is seen. The arbiter does not buffer, so a dropped valid loses the write.
- Fairness: under continuous contention, grants strictly alternate A,B,A,B,…; neither requester waits more than 1 cycle.
- A suppressed R0 write still counts as a grant and updates last_grant.
- conflict_cnt increments on each RUN-state edge with a_valid&&b_valid, saturating at 8'hFF with no wrap. It is not incremented during INIT.
- Throughput: one write per cycle sustained. Same-register writes on consecutive cycles are applied in grant order, so the last granted write wins.

Test Plan:
- Reset then release rst high → rf_WriteReg high for exactly 16 cycles with rf_DstReg 0..15 and rf_DstData 16'h0000. init_busy falls the same edge as the last init write, and no ready is asserted during init.
- Post-init, A only: a_reg=7, a_data=16'h3099 → a_ready=1 that cycle; next cycle rf_WriteReg=1, rf_DstReg=7, rf_DstData=16'h3099. The register-file read of R7 then returns 16'h3099.
- Both valid for 4 cycles (A: R1=16'h1111, then R2, …; B: R3=16'hBBBB, …) → grants A,B,A,B. Each loser holds its request and is accepted the next cycle; conflict_cnt ends at 4.
- ZERO_R0=1, B writes R0=16'h808A → b_ready=1, rf_WriteReg stays 0, and R0 still reads 16'h0000. A following tie goes to A.
- rst pulled low for one cycle in mid-run while both requesters are valid → outputs clear, no write of either pending request, and a full 16-cycle init restarts. Separately, reset at init cnt=9 restarts from R0.
- Hold both valid for 300 run cycles → conflict_cnt saturates at 8'hFF and stays there.
